// File: rtl/universal_register.sv
// n-bit universal register: hold, shift, rotate, load, clear and invert.
// The operation is chosen by ctrl every cycle. Both outputs come straight from flops.
module universal_register #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         serial_in,
   input  logic [n-1:0] D_in,
   input  logic [2:0]   ctrl,
   output logic         serial_out,
   output logic [n-1:0] Q_out
);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_SHR   = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_ROR   = 3'b100;
   localparam logic [2:0] OP_ROL   = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;
   localparam logic [2:0] OP_INV   = 3'b111;

   logic [n-1:0] q_q, q_d;
   logic         so_q, so_d;

   // An unknown ctrl value matches no case item, so it falls through to HOLD.
   always_comb begin
      q_d  = q_q;
      so_d = so_q;
      case (ctrl)
         OP_HOLD: begin
         end
         OP_SHR: begin
            q_d  = {serial_in, q_q[n-1:1]};
            so_d = q_q[0];
         end
         OP_SHL: begin
            q_d  = {q_q[n-2:0], serial_in};
            so_d = q_q[n-1];
         end
         OP_LOAD: begin
            q_d = D_in;
         end
         OP_ROR: begin
            q_d  = {q_q[0], q_q[n-1:1]};
            so_d = q_q[0];
         end
         OP_ROL: begin
            q_d  = {q_q[n-2:0], q_q[n-1]};
            so_d = q_q[n-1];
         end
         OP_CLEAR: begin
            q_d = '0;
         end
         OP_INV: begin
            q_d = ~q_q;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q  <= '0;
         so_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         so_q <= so_d;
      end
   end

   assign Q_out      = q_q;
   assign serial_out = so_q;

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (n=4): directed vectors plus a
// random back-to-back run, with a queue of model predictions popped each cycle.
module tb_universal_register;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         serial_in;
   logic [N-1:0] D_in;
   logic [2:0]   ctrl;
   logic         serial_out;
   logic [N-1:0] Q_out;

   universal_register #(.n(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .D_in       (D_in),
      .ctrl       (ctrl),
      .serial_out (serial_out),
      .Q_out      (Q_out)
   );

   always #5 clk = ~clk;

   logic [N-1:0] m_q;
   logic         m_so;
   logic [N:0]   sb[$];
   int           tests_run = 0;
   int           tests_failed = 0;

   // Drive one cycle of stimulus, update the reference model, queue its prediction.
   task automatic drive_op(input logic rst, input logic [2:0] op, input logic si,
                           input logic [N-1:0] d);
      logic [N-1:0] old;
      @(negedge clk);
      rst_n = rst; ctrl = op; serial_in = si; D_in = d;
      old = m_q;
      if (!rst) begin
         m_q = '0; m_so = 1'b0;
      end else begin
         case (op)
            3'd1: begin m_so = old[0];   m_q = (old >> 1) | (N'(si) << (N-1)); end
            3'd2: begin m_so = old[N-1]; m_q = (old << 1) | N'(si); end
            3'd3: m_q = d;
            3'd4: begin m_so = old[0];   m_q = (old >> 1) | (N'(old[0]) << (N-1)); end
            3'd5: begin m_so = old[N-1]; m_q = (old << 1) | N'(old[N-1]); end
            3'd6: m_q = '0;
            3'd7: m_q = old ^ {N{1'b1}};
            default: ;
         endcase
      end
      sb.push_back({m_so, m_q});
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [N:0] exp;
      for (int i = 0; i < 5; i++) begin
         drive_op(1'b0, 3'bxxx, 1'b0, '0);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== 4'b0000 || serial_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset[%0d]: got so=%b Q=%b, expected so=%b Q=%b", i, serial_out, Q_out, exp[N], exp[N-1:0]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b1, 3'b000, 1'b1, 4'b1111);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hold[%0d]: got so=%b Q=%b, expected so=%b Q=0000", i, serial_out, Q_out, exp[N]);
         end
      end
   endtask

   task automatic test_load_hold();
      logic [N:0] exp;
      logic [2:0] ops [4] = '{3'b011, 3'b000, 3'b000, 3'b000};
      for (int i = 0; i < 4; i++) begin
         drive_op(1'b1, ops[i], 1'b1, (i == 0) ? 4'b0011 : 4'b1100);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== 4'b0011 || serial_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_hold[%0d]: got so=%b Q=%b, expected so=0 Q=0011", i, serial_out, Q_out);
         end
      end
   endtask

   task automatic test_shift();
      logic [N:0]   exp;
      logic [2:0]   ops [4] = '{3'b001, 3'b001, 3'b011, 3'b010};
      logic         sis [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [N-1:0] eq  [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         drive_op(1'b1, ops[i], sis[i], 4'b1000);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== eq[i] || serial_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL shift[%0d]: got so=%b Q=%b, expected so=1 Q=%b", i, serial_out, Q_out, eq[i]);
         end
      end
   endtask

   task automatic test_rotate();
      logic [N:0]   exp;
      logic [2:0]   ops [7] = '{3'b011, 3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
      logic [N-1:0] eq  [7] = '{4'b0011, 4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
      logic         eso [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         drive_op(1'b1, ops[i], 1'b0, 4'b0011);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== eq[i] || serial_out !== eso[i]) begin
            tests_failed++;
            $display("FAIL rotate[%0d]: got so=%b Q=%b, expected so=%b Q=%b", i, serial_out, Q_out, eso[i], eq[i]);
         end
      end
   endtask

   task automatic test_clear_invert();
      logic [N:0]   exp;
      logic [2:0]   ops [3] = '{3'b011, 3'b111, 3'b110};
      logic [N-1:0] eq  [3] = '{4'b0011, 4'b1100, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b1, ops[i], 1'b0, 4'b0011);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== eq[i] || serial_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_invert[%0d]: got so=%b Q=%b, expected so=1 Q=%b", i, serial_out, Q_out, eq[i]);
         end
      end
   endtask

   task automatic test_reset_wins();
      logic [N:0]   exp;
      logic         rs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0]   ops [4] = '{3'b011, 3'b010, 3'b111, 3'b001};
      logic [N-1:0] eq  [4] = '{4'b1010, 4'b0000, 4'b1111, 4'b1111};
      logic         eso [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_op(rs[i], ops[i], 1'b1, 4'b1010);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== eq[i] || serial_out !== eso[i]) begin
            tests_failed++;
            $display("FAIL reset_wins[%0d]: got so=%b Q=%b, expected so=%b Q=%b", i, serial_out, Q_out, eso[i], eq[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [N:0]   exp;
      logic [N-1:0] eq  [8] = '{4'b0011, 4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b0011, 4'b0000, 4'b1111};
      logic         eso [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      drive_op(1'b0, 3'b000, 1'b0, 4'b0011);
      drive_op(1'b1, 3'b011, 1'b0, 4'b0011);
      void'(sb.pop_front());
      void'(sb.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive_op(1'b1, 3'(i), 1'b0, 4'b0011);
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp || Q_out !== eq[i] || serial_out !== eso[i]) begin
            tests_failed++;
            $display("FAIL sweep[ctrl=%0d]: got so=%b Q=%b, expected so=%b Q=%b", i, serial_out, Q_out, eso[i], eq[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N:0] exp;
      for (int i = 0; i < 300; i++) begin
         drive_op(($urandom_range(15) != 0), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  N'($urandom_range(15)));
         exp = sb.pop_front();
         tests_run++;
         if ({serial_out, Q_out} !== exp) begin
            tests_failed++;
            $display("FAIL back_to_back[%0d]: got so=%b Q=%b, expected so=%b Q=%b", i, serial_out, Q_out, exp[N], exp[N-1:0]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; ctrl = 3'b000; serial_in = 1'b0; D_in = '0;
      m_q = '0; m_so = 1'b0;
      test_reset();
      test_load_hold();
      test_shift();
      test_rotate();
      test_clear_invert();
      test_reset_wins();
      test_sweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
